// File: rtl/gray_hist_pkg.sv
// gray_hist_pkg: shared constants, state encoding and sizing helper for the
// grey-level histogram engine (gray_hist_stat and its bin RAM).
package gray_hist_pkg;

    localparam int NUM_BINS  = 256;
    localparam int DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DUMP  = 3'd4
    } hist_state_e;

    // Smallest bin-counter width that can hold a full frame of one grey level.
    function automatic int min_cnt_w(input int pixels);
        return $clog2(pixels + 1);
    endfunction

endpackage

// File: rtl/gray_hist_stat_ram.sv
// hist_ram_sdp: 2^ADDR_W x DATA_W simple dual-port synchronous RAM.
// Ports: clk; we/waddr/wdata write port; raddr read address, rdata read data
// one cycle later. A read and write to the same address in the same cycle
// returns the old contents.
module hist_ram_sdp #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 19
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(1 << ADDR_W)-1];

    // Write port and registered read port; read sees pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/gray_hist_stat.sv
// gray_hist_stat: per-frame 256-bin grey-level histogram.
// Accumulates bin counts while vsync is high, then streams bins 0..255
// (one per cycle, no backpressure) and clears the RAM in the same pass.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   per_img_vsync/per_img_href/per_img_gray : pixel stream in
//   init_done  : power-up RAM clear finished
//   hist_vld/hist_bin/hist_cnt/hist_last : bin stream out
//   frame_err  : pulse with hist_last when the pixel total is not HDISP*VDISP
//   frame_drop : pulse when a frame start is ignored
// Build option: define HIST_CUMULATIVE_EN to output the saturating running
// CDF on hist_cnt instead of the raw bin count.
module gray_hist_stat
    import gray_hist_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int CNT_W     = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             per_img_vsync,
    input  logic             per_img_href,
    input  logic [7:0]       per_img_gray,
    output logic             init_done,
    output logic             hist_vld,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_cnt,
    output logic             hist_last,
    output logic             frame_err,
    output logic             frame_drop
);

    localparam logic [2:0] S_INIT  = 3'(ST_INIT);
    localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
    localparam logic [2:0] S_ACCUM = 3'(ST_ACCUM);
    localparam logic [2:0] S_DRAIN = 3'(ST_DRAIN);
    localparam logic [2:0] S_DUMP  = 3'(ST_DUMP);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(IMG_HDISP * IMG_VDISP);
    // INIT and DUMP both spend 256 RAM cycles plus one closing cycle.
    localparam logic [8:0]       SEQ_END   = 9'(NUM_BINS);
    localparam logic [8:0]       DRAIN_END = 9'(DRAIN_CYC - 1);

    logic [2:0]       state_r, state_nxt_s;
    logic [8:0]       seq_cnt_r;
    logic             vsync_d_r;
    logic             vs_rise_s, vs_fall_s, pix_acc_s, dump_rd_s;
    logic             p1_vld_r;
    logic [7:0]       p1_addr_r;
    logic             fwd_vld_r;
    logic [7:0]       fwd_addr_r;
    logic [CNT_W-1:0] fwd_data_r;
    logic [CNT_W-1:0] ram_q_s, base_s, inc_s;
    logic             ram_we_s;
    logic [7:0]       ram_waddr_s, ram_raddr_s;
    logic [CNT_W-1:0] ram_wdata_s;
    logic [CNT_W-1:0] pix_total_r;
    logic             init_done_r, hist_vld_r, hist_last_r, frame_err_r, frame_drop_r;
    logic [7:0]       hist_bin_r;

    assign vs_rise_s = per_img_vsync & ~vsync_d_r;
    assign vs_fall_s = ~per_img_vsync & vsync_d_r;
    assign pix_acc_s = (state_r == S_ACCUM) & per_img_href;
    assign dump_rd_s = (state_r == S_DUMP) & ~seq_cnt_r[8];

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_INIT:  if (seq_cnt_r == SEQ_END)   state_nxt_s = S_IDLE;  else state_nxt_s = S_INIT;
            S_IDLE:  if (vs_rise_s)              state_nxt_s = S_ACCUM; else state_nxt_s = S_IDLE;
            S_ACCUM: if (vs_fall_s)              state_nxt_s = S_DRAIN; else state_nxt_s = S_ACCUM;
            S_DRAIN: if (seq_cnt_r == DRAIN_END) state_nxt_s = S_DUMP;  else state_nxt_s = S_DRAIN;
            S_DUMP:  if (seq_cnt_r == SEQ_END)   state_nxt_s = S_IDLE;  else state_nxt_s = S_DUMP;
            default: state_nxt_s = S_INIT;
        endcase
    end

    // State register, per-state cycle counter and vsync history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_INIT;
            seq_cnt_r <= 9'd0;
            vsync_d_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            vsync_d_r <= per_img_vsync;
            if (state_nxt_s != state_r) begin
                seq_cnt_r <= 9'd0;
            end else if (state_r == S_INIT || state_r == S_DRAIN || state_r == S_DUMP) begin
                seq_cnt_r <= seq_cnt_r + 9'd1;
            end else begin
                seq_cnt_r <= 9'd0;
            end
        end
    end

    // Increment base: the RAM returns stale data when the previous pixel's
    // write to the same bin lands in the same cycle as this pixel's read.
    always_comb begin
        if (fwd_vld_r && (fwd_addr_r == p1_addr_r)) begin
            base_s = fwd_data_r;
        end else begin
            base_s = ram_q_s;
        end
        if (base_s == CNT_MAX) begin
            inc_s = CNT_MAX;
        end else begin
            inc_s = base_s + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // RAM port steering: clear writes in INIT/DUMP, otherwise the RMW write.
    always_comb begin
        ram_we_s    = p1_vld_r;
        ram_waddr_s = p1_addr_r;
        ram_wdata_s = inc_s;
        ram_raddr_s = per_img_gray;
        case (state_r)
            S_INIT: begin
                ram_we_s    = ~seq_cnt_r[8];
                ram_waddr_s = seq_cnt_r[7:0];
                ram_wdata_s = {CNT_W{1'b0}};
            end
            S_DUMP: begin
                ram_we_s    = ~seq_cnt_r[8];
                ram_waddr_s = seq_cnt_r[7:0];
                ram_wdata_s = {CNT_W{1'b0}};
                ram_raddr_s = seq_cnt_r[7:0];
            end
            default: begin
                ram_we_s = p1_vld_r;
            end
        endcase
    end

    // RMW pipeline stages, forwarding copy of the last write, pixel total.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_vld_r    <= 1'b0;
            p1_addr_r   <= 8'd0;
            fwd_vld_r   <= 1'b0;
            fwd_addr_r  <= 8'd0;
            fwd_data_r  <= {CNT_W{1'b0}};
            pix_total_r <= {CNT_W{1'b0}};
        end else begin
            p1_vld_r   <= pix_acc_s;
            p1_addr_r  <= per_img_gray;
            fwd_vld_r  <= p1_vld_r;
            fwd_addr_r <= p1_addr_r;
            fwd_data_r <= inc_s;
            if (state_r == S_IDLE && vs_rise_s) begin
                pix_total_r <= {CNT_W{1'b0}};
            end else if (pix_acc_s && pix_total_r != CNT_MAX) begin
                pix_total_r <= pix_total_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                pix_total_r <= pix_total_r;
            end
        end
    end

    // Output-side status registers; bin data follows the RAM read by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_done_r  <= 1'b0;
            hist_vld_r   <= 1'b0;
            hist_bin_r   <= 8'd0;
            hist_last_r  <= 1'b0;
            frame_err_r  <= 1'b0;
            frame_drop_r <= 1'b0;
        end else begin
            if (state_r == S_INIT && seq_cnt_r == SEQ_END) begin
                init_done_r <= 1'b1;
            end else begin
                init_done_r <= init_done_r;
            end
            hist_vld_r   <= dump_rd_s;
            hist_bin_r   <= seq_cnt_r[7:0];
            hist_last_r  <= dump_rd_s & (seq_cnt_r[7:0] == 8'hFF);
            frame_err_r  <= dump_rd_s & (seq_cnt_r[7:0] == 8'hFF) & (pix_total_r != FRAME_PIX);
            frame_drop_r <= vs_rise_s & (state_r == S_INIT || state_r == S_DRAIN || state_r == S_DUMP);
        end
    end

    hist_ram_sdp #(
        .ADDR_W (8),
        .DATA_W (CNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (ram_raddr_s),
        .rdata (ram_q_s)
    );

`ifdef HIST_CUMULATIVE_EN
    logic [CNT_W-1:0] cdf_r, cdf_base_s, cdf_next_s;
    logic [CNT_W:0]   cdf_sum_s;

    // Running CDF, restarted at bin 0, saturating.
    always_comb begin
        if (hist_bin_r == 8'd0) begin
            cdf_base_s = {CNT_W{1'b0}};
        end else begin
            cdf_base_s = cdf_r;
        end
        cdf_sum_s = {1'b0, cdf_base_s} + {1'b0, ram_q_s};
        if (cdf_sum_s[CNT_W]) begin
            cdf_next_s = CNT_MAX;
        end else begin
            cdf_next_s = cdf_sum_s[CNT_W-1:0];
        end
        if (hist_vld_r) begin
            hist_cnt = cdf_next_s;
        end else begin
            hist_cnt = {CNT_W{1'b0}};
        end
    end

    // CDF accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdf_r <= {CNT_W{1'b0}};
        end else if (hist_vld_r) begin
            cdf_r <= cdf_next_s;
        end else begin
            cdf_r <= cdf_r;
        end
    end
`else
    // Raw bin count, held at zero outside the dump stream.
    always_comb begin
        if (hist_vld_r) begin
            hist_cnt = ram_q_s;
        end else begin
            hist_cnt = {CNT_W{1'b0}};
        end
    end
`endif

    assign init_done  = init_done_r;
    assign hist_vld   = hist_vld_r;
    assign hist_bin   = hist_bin_r;
    assign hist_last  = hist_last_r;
    assign frame_err  = frame_err_r;
    assign frame_drop = frame_drop_r;

endmodule

// File: tb/tb_gray_hist_stat.sv
// Randomised bench for gray_hist_stat on a small 16x8 frame with 8-bit bins,
// so bin and pixel-total saturation are reachable. Expected histograms come
// from a plain per-bin count array updated for every pixel driven into an
// accepted frame.
module tb_gray_hist_stat;

    localparam int H    = 16;
    localparam int V    = 8;
    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, vsync, href;
    logic [7:0]    gray;
    logic          init_done, hist_vld, hist_last, frame_err, frame_drop;
    logic [7:0]    hist_bin;
    logic [CW-1:0] hist_cnt;

    always #5 clk = ~clk;

    gray_hist_stat #(.IMG_HDISP(H), .IMG_VDISP(V), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_img_vsync(vsync), .per_img_href(href), .per_img_gray(gray),
        .init_done(init_done), .hist_vld(hist_vld), .hist_bin(hist_bin),
        .hist_cnt(hist_cnt), .hist_last(hist_last),
        .frame_err(frame_err), .frame_drop(frame_drop)
    );

    int n_chk = 0;
    int n_pass = 0;
    int model [256];
    int model_total;
    int ntick = 0;
    int fall_tick;
    int got_cnt [256];
    int got_bin_at [256];
    int n_vld, first_vld, last_tick, last_cnt, err_pulses, drop_pulses;
    logic err_at_last;
    int run_left = 0;
    int run_len = 0;
    logic [7:0] run_val = 8'd6;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_capture();
        for (int i = 0; i < 256; i++) begin
            got_cnt[i] = -1;
            got_bin_at[i] = -1;
        end
        n_vld = 0; first_vld = -1; last_tick = -1; last_cnt = 0;
        err_pulses = 0; drop_pulses = 0; err_at_last = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = 0;
        model_total = 0;
    endtask

    // One clock: wait for the falling edge, then record what the DUT shows.
    task automatic tick();
        @(negedge clk);
        ntick++;
        if (hist_vld) begin
            if (n_vld == 0) first_vld = ntick;
            if (n_vld < 256) begin
                got_bin_at[n_vld] = int'(hist_bin);
                got_cnt[hist_bin] = int'(hist_cnt);
            end
            n_vld++;
        end
        if (hist_last) begin
            last_tick = ntick;
            last_cnt++;
            err_at_last = frame_err;
        end
        if (frame_err) err_pulses++;
        if (frame_drop) drop_pulses++;
    endtask

    task automatic next_gray(input int mode, input int col, output logic [7:0] g);
        case (mode)
            0: g = 8'h80;
            1: g = 8'(col);
            2: begin
                if (run_left == 0) begin
                    run_val  = (run_val == 8'd5) ? 8'd6 : 8'd5;
                    run_len  = (run_len % 3) + 1;
                    run_left = run_len;
                end
                g = run_val;
                run_left--;
            end
            3: g = 8'($urandom_range(0, 255));
            4: g = ($urandom_range(0, 1) == 0) ? 8'd3 : 8'd4;
            default: g = 8'hFF;
        endcase
    endtask

    task automatic drive_frame(input int rows, input bit do_rise, input int mode, input bit last_on_fall);
        logic [7:0] g;
        clear_capture();
        href = 1'b0;
        if (do_rise) begin
            vsync = 1'b1;
            tick();
        end
        repeat (3) tick();
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < H; c++) begin
                next_gray(mode, c, g);
                gray = g;
                href = 1'b1;
                if (last_on_fall && r == rows - 1 && c == H - 1) begin
                    vsync = 1'b0;
                    fall_tick = ntick;
                end
                model[g]++;
                model_total++;
                tick();
            end
            href = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        if (!(last_on_fall && rows > 0)) begin
            href = 1'b0;
            vsync = 1'b0;
            fall_tick = ntick;
            tick();
        end
    endtask

    // Let the dump run out; optionally raise vsync at fall cycle + rise_off.
    task automatic collect(input int rise_off);
        href = 1'b0;
        while (ntick - fall_tick < 262) begin
            if (ntick - fall_tick == rise_off) vsync = 1'b1;
            tick();
        end
    endtask

    task automatic verify(input string tag, input int exp_drop);
        logic exp_err;
        int bad_order, sat, cdf, expv;
        exp_err = (model_total != H * V);
        check({tag, "_nvld"}, n_vld, 256);
        check({tag, "_first_vld"}, first_vld - fall_tick, 4);
        check({tag, "_last_at"}, last_tick - fall_tick, 259);
        check({tag, "_last_cnt"}, last_cnt, 1);
        check({tag, "_err_at_last"}, 32'(err_at_last), 32'(exp_err));
        check({tag, "_err_pulses"}, err_pulses, 32'(exp_err));
        check({tag, "_drop"}, drop_pulses, exp_drop);
        bad_order = 0;
        for (int i = 0; i < 256; i++) if (got_bin_at[i] != i) bad_order++;
        check({tag, "_bin_order"}, bad_order, 0);
        cdf = 0;
        for (int i = 0; i < 256; i++) begin
            sat = (model[i] > MAXV) ? MAXV : model[i];
            cdf = cdf + sat;
            if (cdf > MAXV) cdf = MAXV;
`ifdef HIST_CUMULATIVE_EN
            expv = cdf;
`else
            expv = sat;
`endif
            check($sformatf("%s_bin%0d", tag, i), got_cnt[i], expv);
        end
        clear_model();
    endtask

    task automatic do_reset(input int low_ticks, input bit check_vals);
        int rel;
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; gray = 8'd0;
        repeat (low_ticks) tick();
        if (check_vals) begin
            check("rst_init_done", 32'(init_done), 0);
            check("rst_hist_vld", 32'(hist_vld), 0);
            check("rst_hist_bin", 32'(hist_bin), 0);
            check("rst_hist_cnt", 32'(hist_cnt), 0);
            check("rst_hist_last", 32'(hist_last), 0);
            check("rst_frame_err", 32'(frame_err), 0);
            check("rst_frame_drop", 32'(frame_drop), 0);
        end
        rst_n = 1'b1;
        rel = ntick;
        while (ntick < rel + 256) tick();
        check("init_done_low_256", 32'(init_done), 0);
        tick();
        check("init_done_high_257", 32'(init_done), 1);
        clear_model();
    endtask

    initial begin
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; gray = 8'd0;
        clear_model();
        clear_capture();
        do_reset(3, 1'b1);
        repeat (4) tick();

        drive_frame(V, 1'b1, 0, 1'b0); collect(-1); verify("uniform", 0);
        drive_frame(V, 1'b1, 1, 1'b0); collect(-1); verify("ramp", 0);
        drive_frame(V, 1'b1, 2, 1'b1); collect(-1); verify("runs_fall_pix", 0);
        drive_frame(V, 1'b1, 4, 1'b0); collect(-1); verify("fwd_second", 0);
        drive_frame(V, 1'b1, 3, 1'b0); collect(-1); verify("random", 0);

        // Short frame, then a new frame start 100 cycles after the fall.
        drive_frame(3, 1'b1, 3, 1'b0); collect(100); verify("short", 1);
        clear_capture();
        href = 1'b1; gray = 8'd9;
        repeat (10) tick();
        href = 1'b0; vsync = 1'b0;
        repeat (300) tick();
        check("dropped_no_dump", n_vld, 0);
        check("dropped_no_more_drop", drop_pulses, 0);

        // Blanking boundary: F+259 is too early, F+260 is accepted.
        drive_frame(V, 1'b1, 3, 1'b0); collect(259); verify("blank259", 1);
        repeat (5) tick();
        vsync = 1'b0;
        repeat (5) tick();
        drive_frame(V, 1'b1, 4, 1'b0); collect(260); verify("blank260", 0);
        drive_frame(V, 1'b0, 3, 1'b0); collect(-1); verify("after260", 0);

        drive_frame(0, 1'b1, 0, 1'b0); collect(-1); verify("empty", 0);
        drive_frame(24, 1'b1, 5, 1'b0); collect(-1); verify("saturate", 0);

        // Reset in the middle of a frame, then a clean frame.
        vsync = 1'b1; tick();
        for (int i = 0; i < 20; i++) begin
            href = 1'b1; gray = 8'($urandom_range(0, 255)); tick();
        end
        do_reset(1, 1'b0);
        repeat (3) tick();
        drive_frame(V, 1'b1, 3, 1'b0); collect(-1); verify("post_reset", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gray_hist_stat.md
# gray_hist_stat

Per-frame 256-bin grey-level histogram engine. It sits directly downstream of `mean_filter_proc` and consumes its `post_img_vsync`/`post_img_href`/`post_img_gray` stream. After each frame it streams the 256 bin counts out and clears them in the same pass, feeding contrast-stretch and equalisation stages.

## Interface
- `IMG_HDISP`, 640, active pixels per line.
- `IMG_VDISP`, 480, active lines per frame.
- `CNT_W`, 19, bin counter width; must satisfy 2^CNT_W > IMG_HDISP*IMG_VDISP.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `per_img_vsync`  in  1  frame valid, high for the whole frame.
- `per_img_href`  in  1  pixel valid.
- `per_img_gray`  in  8  pixel grey value.
- `init_done`  out  1  high once the power-up RAM clear has finished.
- `hist_vld`  out  1  bin output valid.
- `hist_bin`  out  8  bin index.
- `hist_cnt`  out  CNT_W  bin count, or cumulative count (see Configuration).
- `hist_last`  out  1  high with bin 255.
- `frame_err`  out  1  one-cycle pulse with `hist_last` when the accepted pixel total is not IMG_HDISP*IMG_VDISP.
- `frame_drop`  out  1  one-cycle pulse when a frame start is ignored.

## Operation
- **Reset values.** All outputs are 0. The state goes to INIT, from any state. Reset mid-frame or mid-dump discards all data.
- **States:**
  - INIT: writes 0 to addresses 0..255, one per cycle, 256 cycles. Then sets `init_done` and goes to IDLE.
  - IDLE: on a vsync rise, goes to ACCUM.
  - ACCUM: on a vsync fall, goes to DRAIN.
  - DRAIN: 2 cycles, then goes to DUMP.
  - DUMP: 256 read-and-clear cycles, then goes to IDLE.
- **Edge detection.** Vsync edges come from `per_img_vsync` against a 1-cycle registered copy.
- **Dropped frames.** A vsync rise in INIT, DRAIN or DUMP pulses `frame_drop`. That entire frame is ignored, including its fall.
- **Accumulation (ACCUM, href=1).** Read-modify-write of bin[gray] through a 2-stage pipeline:
  - Read is issued in cycle t.
  - Write of count+1 happens in cycle t+1.
  - If gray(t) equals gray(t-1), the increment uses the forwarded value from t-1, not the RAM output. Back-to-back equal pixels must count correctly.
- **Ignored input.** href while the state is not ACCUM is ignored.
- **Pixel total.** A CNT_W-bit pixel-total counter increments for every accepted pixel and clears on entry to ACCUM.
- **Saturation.** Bin increments saturate at 2^CNT_W-1; no wrap.
- **Dump.** Reads addresses 0..255 in order, one per cycle, and writes 0 back to each address in the same pass. The RAM is therefore all-zero when the state returns to IDLE.
- **Edge cases:**
  - A frame with zero href still dumps 256 zero bins and asserts `frame_err`.
  - A vsync fall in the same cycle as href=1 still counts that pixel.

## Timing
- **RAM.** Simple dual-port; read latency 1 cycle; read-during-write to the same address returns old data (hence the forwarding).
- **Dump timing.** Let F be the cycle in which the vsync fall is detected:
  - DRAIN occupies F+1 and F+2.
  - DUMP reads occur in F+3..F+258.
  - `hist_vld` is high in F+4..F+259, contiguous, `hist_bin` 0..255.
  - `hist_last` and `frame_err` occur in F+259.
  - IDLE from F+260.
- **Min vertical blanking.** A new vsync rise is accepted only at F+260 or later; an earlier rise is a dropped frame.
- **Init.** `init_done` rises 257 cycles after `rst_n` is released.
- **Backpressure.** None; the consumer must accept one bin per cycle.

## Configuration
- `HIST_CUMULATIVE_EN`:
  - Defined: `hist_cnt` outputs the running CDF, sum of bins 0..hist_bin, via a CNT_W accumulator cleared at bin 0. It saturates at 2^CNT_W-1. The value at bin 255 equals the pixel total. Latency is unchanged.
  - Undefined: `hist_cnt` is the raw per-bin count.

## Structure
- **Package `gray_hist_pkg`:** `NUM_BINS` = 256, `DRAIN_CYC` = 2, state enum (INIT, IDLE, ACCUM, DRAIN, DUMP), and a `clog2`-based helper for the minimum CNT_W.
- **Sub-module `hist_ram_sdp`:** 256 x CNT_W simple dual-port sync RAM, 1-cycle read, old-data-on-collision. All forwarding and control logic stays in `gray_hist_stat`.

## Test plan
- **Uniform frame.** Reset, wait for `init_done`, then a 640x480 frame of all 8'h80 → bin 128 = 307200, all other bins 0, `frame_err`=0.
- **Ramp.** Frame with gray = col[7:0] for every row → bins 0..127 each = 1440, bins 128..255 each = 960. With `HIST_CUMULATIVE_EN`, bin 255 = 307200.
- **Forwarding.** Alternating runs of length 1, 2 and 3 of values 5 and 6 → bin counts exactly match a software model. Two consecutive frames → the second frame's counts are not polluted by the first.
- **Short frame.** Frame with 10 rows only → `frame_err` pulses with `hist_last`, bins total 6400. A vsync rise at F+100 → `frame_drop` pulses and that frame produces no dump.
- **Reset mid-frame.** `rst_n` low for 1 cycle mid-frame, then a full frame → `init_done` low for 257 cycles, then a correct histogram with no residue.
